// File: rtl/dh_pkg.sv
// Shared types and widths for the modular-exponentiation controller.
package dh_pkg;

  localparam int OP_W  = 8;
  localparam int DIV_W = 16;

  typedef enum logic [3:0] {
    IDLE, RED_BASE, SQ, SQ_WAIT, MUL, MUL_WAIT, GAP, NEXT, FIN
  } state_t;

  // Which reduction the GAP state is returning from.
  typedef enum logic [1:0] {
    OP_BASE, OP_SQ, OP_MUL
  } op_t;

  function automatic logic [DIV_W-1:0] mul8(input logic [OP_W-1:0] a,
                                            input logic [OP_W-1:0] b);
    return {{(DIV_W-OP_W){1'b0}}, a} * {{(DIV_W-OP_W){1'b0}}, b};
  endfunction

endpackage

// File: rtl/mod_exp_ctrl.sv
// MSB-first square-and-multiply g^e mod p, using an external divider for
// every reduction. NEXT issues the first squaring of a new bit index.
module mod_exp_ctrl
  import dh_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OP_W-1:0]  base,
  input  logic [DIV_W-1:0] exponent,
  input  logic [OP_W-1:0]  modulus,
  output logic [OP_W-1:0]  result,
  output logic             done,
  output logic             busy,
  output logic             err,
  output logic [DIV_W-1:0] div_dividend,
  output logic [DIV_W-1:0] div_divider,
  output logic             div_start,
  input  logic             div_ready,
  input  logic [DIV_W-1:0] div_remainder
);

  state_t           state, state_n;
  op_t              last_op;
  logic [DIV_W-1:0] e_q;
  logic [OP_W-1:0]  p_q;
  logic [OP_W-1:0]  gp;
  logic [OP_W-1:0]  r;
  logic [3:0]       idx;
  logic             accept;
  logic             capture;
  logic             trivial;
  logic             unused_rem_hi;

  assign trivial       = (modulus <= 8'd1);
  assign div_divider   = {{(DIV_W-OP_W){1'b0}}, p_q};
  assign unused_rem_hi = ^div_remainder[DIV_W-1:OP_W];

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    capture = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_n = trivial ? FIN : RED_BASE;
        end
      end
      RED_BASE, SQ_WAIT, MUL_WAIT: begin
        if (div_ready) begin
          capture = 1'b1;
          state_n = GAP;
        end
      end
      SQ, NEXT: begin
        capture = div_ready;
        state_n = div_ready ? GAP : SQ_WAIT;
      end
      MUL: begin
        capture = div_ready;
        state_n = div_ready ? GAP : MUL_WAIT;
      end
      GAP: begin
        unique case (last_op)
          OP_BASE: state_n = SQ;
          OP_SQ:   state_n = e_q[idx] ? MUL : ((idx == 4'd0) ? FIN : NEXT);
          default: state_n = (idx == 4'd0) ? FIN : NEXT;
        endcase
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      result       <= '0;
      done         <= 1'b0;
      busy         <= 1'b0;
      err          <= 1'b0;
      div_start    <= 1'b0;
      div_dividend <= '0;
      idx          <= 4'd0;
      r            <= '0;
      last_op      <= OP_BASE;
    end else begin
      state <= state_n;
      done  <= (state_n == FIN);

      if (accept) begin
        err     <= (modulus == 8'd0);
        r       <= 8'd1;
        idx     <= 4'd15;
        last_op <= OP_BASE;
        if (!trivial) begin
          div_start    <= 1'b1;
          div_dividend <= {{(DIV_W-OP_W){1'b0}}, base};
        end
      end

      if (capture) begin
        div_start <= 1'b0;
        if (state != RED_BASE) r <= div_remainder[OP_W-1:0];
      end

      // GAP -> issue: raise div_start together with the new operand
      if (state == GAP) begin
        unique case (state_n)
          SQ: begin
            div_start    <= 1'b1;
            div_dividend <= mul8(r, r);
            last_op      <= OP_SQ;
          end
          NEXT: begin
            div_start    <= 1'b1;
            div_dividend <= mul8(r, r);
            last_op      <= OP_SQ;
            idx          <= idx - 4'd1;
          end
          MUL: begin
            div_start    <= 1'b1;
            div_dividend <= mul8(r, gp);
            last_op      <= OP_MUL;
          end
          default: ;
        endcase
      end

      if (state_n == FIN) begin
        busy   <= 1'b0;
        result <= (state == IDLE) ? 8'd0 : r;
      end else if (accept) begin
        busy <= 1'b1;
      end
    end
  end

  // Operand registers carry no reset; they are always loaded on accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      e_q <= exponent;
      p_q <= modulus;
    end
    if (capture && state == RED_BASE) gp <= div_remainder[OP_W-1:0];
  end

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Directed bench for mod_exp_ctrl with a behavioural divider on the negedge.
module tb_mod_exp_ctrl;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [7:0]  base, modulus, result;
  logic [15:0] exponent, div_dividend, div_divider;
  logic [15:0] div_remainder = 16'd0;
  logic        done, busy, err, div_start;
  logic        div_ready = 1'b0;

  always #5 clk = ~clk;

  mod_exp_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .base(base), .exponent(exponent),
    .modulus(modulus), .result(result), .done(done), .busy(busy), .err(err),
    .div_dividend(div_dividend), .div_divider(div_divider),
    .div_start(div_start), .div_ready(div_ready), .div_remainder(div_remainder)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Divider model plus protocol monitors.
  bit          pending = 0, prev_start = 0, seen_rise = 0;
  int          cnt = 0, nreq = 0, rises = 0, gap_bad = 0, unstable = 0;
  int          low_cnt = 0, done_cnt = 0;
  logic [15:0] held_dvd = 0, held_dvr = 0, first_dvd = 0, first_rem = 0;

  always @(negedge clk) begin
    div_ready = 1'b0;
    if (done) done_cnt++;
    if (!busy) seen_rise = 0;
    if (pending) begin
      if (div_start && div_dividend !== held_dvd) unstable++;
      if (cnt == 0) begin
        div_ready     = 1'b1;
        div_remainder = (held_dvr == 16'd0) ? 16'd0 : held_dvd % held_dvr;
        pending       = 0;
      end else begin
        cnt--;
      end
    end else if (div_start && !prev_start) begin
      rises++;
      if (seen_rise && low_cnt != 1) gap_bad++;
      if (!seen_rise) begin
        first_dvd = div_dividend;
        first_rem = (div_divider == 16'd0) ? 16'd0 : div_dividend % div_divider;
      end
      seen_rise = 1;
      pending   = 1;
      held_dvd  = div_dividend;
      held_dvr  = div_divider;
      cnt       = nreq % 3;
      nreq++;
    end
    if (div_start) low_cnt = 0;
    else low_cnt++;
    prev_start = div_start;
  end

  task automatic run(input string tag, input logic [7:0] g, input logic [15:0] e,
                     input logic [7:0] p, input logic [7:0] exp_r, input logic exp_e,
                     input int exp_rises, input bit repulse);
    int r0, d0;
    bit got;
    @(posedge clk); #1;
    base = g; exponent = e; modulus = p; start = 1'b1;
    r0 = rises; d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b0; base = 8'hAA; exponent = 16'h5555; modulus = 8'd3;
    got = 0;
    for (int i = 0; i < 4000; i++) begin
      if (done) begin
        got = 1;
        break;
      end
      start = (repulse && i == 20);
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk({tag, "/done_seen"}, 32'(got), 32'd1);
    chk({tag, "/result"}, 32'(result), 32'(exp_r));
    chk({tag, "/err"}, 32'(err), 32'(exp_e));
    chk({tag, "/busy_at_done"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk({tag, "/done_one_cycle"}, 32'(done), 32'd0);
    chk({tag, "/result_held"}, 32'(result), 32'(exp_r));
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "/done_pulses"}, 32'(done_cnt - d0), 32'd1);
    chk({tag, "/div_starts"}, 32'(rises - r0), 32'(exp_rises));
    chk({tag, "/idle_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int d0;
    bit hit;
    rst = 1'b1; start = 1'b0; base = '0; exponent = '0; modulus = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset/result", 32'(result), 32'd0);
    chk("reset/done", 32'(done), 32'd0);
    chk("reset/busy", 32'(busy), 32'd0);
    chk("reset/err", 32'(err), 32'd0);
    chk("reset/div_start", 32'(div_start), 32'd0);
    chk("reset/div_dividend", 32'(div_dividend), 32'd0);
    rst = 1'b0;

    // reductions = 1 base + 16 squarings + popcount(e)
    run("g3e5p7", 8'd3, 16'd5, 8'd7, 8'd5, 1'b0, 19, 0);
    run("g5e6p23", 8'd5, 16'd6, 8'd23, 8'd8, 1'b0, 19, 0);
    run("g200e2p13", 8'd200, 16'd2, 8'd13, 8'd12, 1'b0, 18, 0);
    chk("g200e2p13/base_dividend", 32'(first_dvd), 32'd200);
    chk("g200e2p13/base_remainder", 32'(first_rem), 32'd5);
    run("e0p23", 8'd9, 16'd0, 8'd23, 8'd1, 1'b0, 17, 0);
    run("g7e3p7", 8'd7, 16'd3, 8'd7, 8'd0, 1'b0, 19, 0);
    run("p0", 8'd4, 16'd1234, 8'd0, 8'd0, 1'b1, 0, 0);
    run("p1", 8'd4, 16'd1234, 8'd1, 8'd0, 1'b0, 0, 0);

    // Reset in the middle of an outstanding reduction.
    @(posedge clk); #1;
    base = 8'd3; exponent = 16'd5; modulus = 8'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    hit = 0;
    for (int i = 0; i < 50; i++) begin
      if (div_start) begin
        hit = 1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("rst_mid/div_start_high", 32'(hit), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    d0 = done_cnt;
    chk("rst_mid/busy", 32'(busy), 32'd0);
    chk("rst_mid/div_start", 32'(div_start), 32'd0);
    chk("rst_mid/done", 32'(done), 32'd0);
    chk("rst_mid/result", 32'(result), 32'd0);
    chk("rst_mid/div_dividend", 32'(div_dividend), 32'd0);
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("rst_mid/stale_ready_busy", 32'(busy), 32'd0);
    chk("rst_mid/stale_ready_result", 32'(result), 32'd0);
    chk("rst_mid/stale_ready_done", 32'(done_cnt - d0), 32'd0);
    chk("rst_mid/stale_ready_div_start", 32'(div_start), 32'd0);
    run("after_rst", 8'd3, 16'd5, 8'd7, 8'd5, 1'b0, 19, 0);

    run("repulse", 8'd3, 16'd5, 8'd7, 8'd5, 1'b0, 19, 1);

    chk("protocol/gap_violations", 32'(gap_bad), 32'd0);
    chk("protocol/unstable_dividend", 32'(unstable), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
